cpu_clock_ctrl: RTL and testbench
=================================

CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 8: width of the divisor and phase counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 2: half-period in clk_in cycles loaded at reset.
REQ-003 SHALL have clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have cfg_div  input  DIV_WIDTH  requested half-period in clk_in cycles.
REQ-006 SHALL have cfg_load  input  1  one-cycle pulse; captures cfg_div as the pending divisor.
REQ-007 SHALL have run  input  1  level; requests continuous CPU clocking.
REQ-008 SHALL have step  input  1  one-cycle pulse; requests exactly one CPU clock period.
REQ-009 SHALL have clk_out  output  1  divided CPU clock, registered.
REQ-010 SHALL have rise  output  1  one-cycle strobe, high in the first clk_in cycle in which clk_out=1.
REQ-011 SHALL have cfg_ack  output  1  one-cycle strobe, high the cycle after the pending divisor becomes active.
REQ-012 SHALL have state  output  2  current state: HALT=0, RUN=1, STEP=2.
REQ-013 SHALL have edge_cnt  output  32  count of clk_out rising edges since reset; wraps modulo 2^32.

Function
REQ-014 SHALL hold div_active (DIV_WIDTH bits); cfg_div=0 SHALL be stored as 1.
REQ-015 SHALL run phase counter cnt from 0 to div_active-1; terminal = (cnt == div_active-1); at terminal cnt<=0, else cnt<=cnt+1.
REQ-016 HALT: cnt held 0, clk_out held 0; run=1 -> RUN; else step=1 -> STEP.
REQ-017 Simultaneous run=1 and step=1 in HALT: RUN wins and step SHALL be dropped.
REQ-018 RUN: at terminal with clk_out=1, clk_out<=0; at terminal with clk_out=0, clk_out<=1 if run=1, else state<=HALT with clk_out kept 0.
REQ-019 Consequence of REQ-018: clk_out SHALL only stop low, after a complete low phase; high phases SHALL never be truncated.
REQ-020 STEP: at the first terminal clk_out<=1; at the second terminal clk_out<=0 and state<=HALT; total 2*div_active cycles, exactly one rise.
REQ-021 step asserted in RUN or STEP SHALL be ignored; run asserted during STEP SHALL take effect only after STEP returns to HALT.
REQ-022 rise and edge_cnt increment SHALL occur together for every 0->1 transition of clk_out.
REQ-023 cfg_load SHALL set pend_div<=cfg_div (0 -> 1) and pend_valid<=1; a later cfg_load before application SHALL overwrite pend_div.
REQ-024 Pending divisor SHALL apply (div_active<=pend_div, pend_valid<=0, cfg_ack next cycle) at the next terminal in RUN/STEP, or the next cycle in HALT.
REQ-025 cfg_load in the same cycle as an application SHALL win: the new value stays pending and the old pending value applies.
REQ-026 Latency: clk_out SHALL first rise div_active+1 clk_in cycles after the cycle run (or step) is sampled high in HALT.

Reset
REQ-027 On rst=1: state=HALT, cnt=0, clk_out=0, rise=0, cfg_ack=0, edge_cnt=0, div_active=DEFAULT_DIV, pend_valid=0; all inputs ignored.
REQ-028 rst mid-operation SHALL force clk_out low on the next edge, even during a high phase.

Verification
REQ-029 Reset, DEFAULT_DIV=2, run=1 held -> clk_out period 4 cycles (2 high/2 low), first rise 3 cycles after run sampled, edge_cnt=3 after 3 periods.
REQ-030 cfg_load cfg_div=3 in HALT, then step pulse -> cfg_ack once, clk_out high exactly 3 cycles, one rise, edge_cnt=1, state back to HALT 6 cycles after STEP entry.
REQ-031 RUN div=2, cfg_load cfg_div=5 mid-phase -> old phase completes, cfg_ack at that terminal, all following phases 5 cycles.
REQ-032 RUN, drop run while clk_out=1 -> high phase completes, full low phase follows, state=HALT, clk_out stays 0, no extra rise.
REQ-033 rst during STEP with clk_out=1 -> next cycle clk_out=0, state=HALT, edge_cnt=0, div_active=2.
REQ-034 cfg_load cfg_div=0 then run -> div_active=1, clk_out toggles every clk_in cycle (period 2), rise every second cycle.

Source files
------------

// File: rtl/cpu_clock_ctrl.sv
// Programmable CPU clock divider: continuous run, single step, or halted low.
// Latency: first clk_out rise div_active+1 clk_in cycles after run/step is sampled in HALT.
// No backpressure; a new divisor only takes effect at a phase boundary or while halted.
module cpu_clock_ctrl #(
   parameter int DIV_WIDTH   = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   input  logic                 cfg_load,
   input  logic                 run,
   input  logic                 step,
   output logic                 clk_out,
   output logic                 rise,
   output logic                 cfg_ack,
   output logic [1:0]           state,
   output logic [31:0]          edge_cnt
);

   localparam logic [1:0] ST_HALT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_STEP = 2'd2;

   logic [DIV_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0] div_active;
   logic [DIV_WIDTH-1:0] pend_div;
   logic                 pend_valid;
   logic [DIV_WIDTH-1:0] cfg_div_nz;
   logic                 terminal;
   logic                 apply;

   always_comb begin
      terminal   = (cnt == div_active - DIV_WIDTH'(1));
      cfg_div_nz = (cfg_div == '0) ? DIV_WIDTH'(1) : cfg_div;
      // Divisor swaps only where cnt returns to 0, so the counter never overshoots.
      apply      = pend_valid && ((state == ST_HALT) ||
                   (((state == ST_RUN) || (state == ST_STEP)) && terminal));
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state      <= ST_HALT;
         cnt        <= '0;
         clk_out    <= 1'b0;
         rise       <= 1'b0;
         cfg_ack    <= 1'b0;
         edge_cnt   <= '0;
         div_active <= DIV_WIDTH'(DEFAULT_DIV);
         pend_div   <= DIV_WIDTH'(DEFAULT_DIV);
         pend_valid <= 1'b0;
      end else begin
         rise    <= 1'b0;
         cfg_ack <= 1'b0;

         if (apply) begin
            div_active <= pend_div;
            pend_valid <= 1'b0;
            cfg_ack    <= 1'b1;
         end
         // A load colliding with an apply stays pending for the next boundary.
         if (cfg_load) begin
            pend_div   <= cfg_div_nz;
            pend_valid <= 1'b1;
         end

         case (state)
            ST_HALT: begin
               cnt     <= '0;
               clk_out <= 1'b0;
               if (run)
                  state <= ST_RUN;
               else if (step)
                  state <= ST_STEP;
            end
            ST_RUN: begin
               cnt <= terminal ? '0 : cnt + DIV_WIDTH'(1);
               if (terminal) begin
                  if (clk_out) begin
                     clk_out <= 1'b0;
                  end else if (run) begin
                     clk_out  <= 1'b1;
                     rise     <= 1'b1;
                     edge_cnt <= edge_cnt + 32'd1;
                  end else begin
                     state <= ST_HALT;
                  end
               end
            end
            ST_STEP: begin
               cnt <= terminal ? '0 : cnt + DIV_WIDTH'(1);
               if (terminal) begin
                  if (!clk_out) begin
                     clk_out  <= 1'b1;
                     rise     <= 1'b1;
                     edge_cnt <= edge_cnt + 32'd1;
                  end else begin
                     clk_out <= 1'b0;
                     state   <= ST_HALT;
                  end
               end
            end
            default: begin
               state   <= ST_HALT;
               cnt     <= '0;
               clk_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl: run, step, divisor reload, halt and reset cases.
module tb_cpu_clock_ctrl;

   logic        clk_in = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  cfg_div = 8'd0;
   logic        cfg_load = 1'b0;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic        clk_out;
   logic        rise;
   logic        cfg_ack;
   logic [1:0]  state;
   logic [31:0] edge_cnt;

   int n_pass  = 0;
   int n_total = 0;

   cpu_clock_ctrl #(.DIV_WIDTH(8), .DEFAULT_DIV(2)) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .cfg_div  (cfg_div),
      .cfg_load (cfg_load),
      .run      (run),
      .step     (step),
      .clk_out  (clk_out),
      .rise     (rise),
      .cfg_ack  (cfg_ack),
      .state    (state),
      .edge_cnt (edge_cnt)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      // Reset
      tick(2);
      chk("rst_clk_out", 32'(clk_out), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_edge_cnt", edge_cnt, 32'd0);
      chk("rst_rise", 32'(rise), 32'd0);
      chk("rst_cfg_ack", 32'(cfg_ack), 32'd0);
      rst = 1'b0;
      tick(1);

      // Continuous run at default divisor 2
      run = 1'b1;
      tick(1);
      chk("run_state", 32'(state), 32'd1);
      chk("run_c1_low", 32'(clk_out), 32'd0);
      tick(1);
      chk("run_c2_low", 32'(clk_out), 32'd0);
      tick(1);
      chk("run_first_rise_clk", 32'(clk_out), 32'd1);
      chk("run_first_rise_strobe", 32'(rise), 32'd1);
      chk("run_first_edge_cnt", edge_cnt, 32'd1);
      tick(1);
      chk("run_c4_high", 32'(clk_out), 32'd1);
      chk("run_c4_rise_clear", 32'(rise), 32'd0);
      tick(1);
      chk("run_c5_low", 32'(clk_out), 32'd0);
      tick(6);
      chk("run_c11_high", 32'(clk_out), 32'd1);
      chk("run_edge_cnt_3", edge_cnt, 32'd3);

      // Drop run during a high phase
      run = 1'b0;
      tick(1);
      chk("stop_high_completes", 32'(clk_out), 32'd1);
      tick(1);
      chk("stop_low_phase", 32'(clk_out), 32'd0);
      chk("stop_still_run", 32'(state), 32'd1);
      tick(1);
      chk("stop_low_phase_end", 32'(state), 32'd1);
      tick(1);
      chk("stop_halt", 32'(state), 32'd0);
      tick(4);
      chk("stop_clk_low", 32'(clk_out), 32'd0);
      chk("stop_no_extra_rise", edge_cnt, 32'd3);

      // Divisor change to 5 in the middle of a high phase
      run = 1'b1;
      tick(3);
      chk("reload_d3_high", 32'(clk_out), 32'd1);
      chk("reload_d3_edge_cnt", edge_cnt, 32'd4);
      cfg_div = 8'd5;
      cfg_load = 1'b1;
      tick(1);
      cfg_load = 1'b0;
      chk("reload_old_phase", 32'(clk_out), 32'd1);
      chk("reload_no_early_ack", 32'(cfg_ack), 32'd0);
      tick(1);
      chk("reload_ack", 32'(cfg_ack), 32'd1);
      chk("reload_d5_low", 32'(clk_out), 32'd0);
      tick(1);
      chk("reload_ack_single", 32'(cfg_ack), 32'd0);
      tick(3);
      chk("reload_d9_low", 32'(clk_out), 32'd0);
      tick(1);
      chk("reload_d10_high", 32'(clk_out), 32'd1);
      chk("reload_d10_rise", 32'(rise), 32'd1);
      chk("reload_d10_edge_cnt", edge_cnt, 32'd5);
      tick(4);
      chk("reload_d14_high", 32'(clk_out), 32'd1);
      tick(1);
      chk("reload_d15_low", 32'(clk_out), 32'd0);
      run = 1'b0;
      tick(4);
      chk("reload_d19_run", 32'(state), 32'd1);
      tick(1);
      chk("reload_d20_halt", 32'(state), 32'd0);

      // Load divisor 3 while halted, then single step
      cfg_div = 8'd3;
      cfg_load = 1'b1;
      tick(1);
      cfg_load = 1'b0;
      chk("step_ack_not_yet", 32'(cfg_ack), 32'd0);
      tick(1);
      chk("step_halt_ack", 32'(cfg_ack), 32'd1);
      tick(1);
      chk("step_halt_ack_single", 32'(cfg_ack), 32'd0);
      step = 1'b1;
      tick(1);
      step = 1'b0;
      chk("step_state", 32'(state), 32'd2);
      chk("step_e4_low", 32'(clk_out), 32'd0);
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(1);
      chk("step_e6_low", 32'(clk_out), 32'd0);
      tick(1);
      chk("step_e7_high", 32'(clk_out), 32'd1);
      chk("step_e7_rise", 32'(rise), 32'd1);
      chk("step_edge_cnt", edge_cnt, 32'd6);
      tick(1);
      chk("step_no_ack", 32'(cfg_ack), 32'd0);
      tick(1);
      chk("step_e9_high", 32'(clk_out), 32'd1);
      chk("step_e9_state", 32'(state), 32'd2);
      tick(1);
      chk("step_end_low", 32'(clk_out), 32'd0);
      chk("step_end_halt", 32'(state), 32'd0);
      tick(2);
      chk("step_one_rise", edge_cnt, 32'd6);

      // Reset during a high step phase
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(3);
      chk("rst_step_high", 32'(clk_out), 32'd1);
      chk("rst_step_edge_cnt", edge_cnt, 32'd7);
      rst = 1'b1;
      tick(1);
      chk("rst_mid_clk_low", 32'(clk_out), 32'd0);
      chk("rst_mid_halt", 32'(state), 32'd0);
      chk("rst_mid_edge_cnt", edge_cnt, 32'd0);
      rst = 1'b0;
      run = 1'b1;
      tick(2);
      chk("rst_div2_low", 32'(clk_out), 32'd0);
      tick(1);
      chk("rst_div2_rise", 32'(clk_out), 32'd1);
      chk("rst_div2_edge_cnt", edge_cnt, 32'd1);
      run = 1'b0;
      tick(4);
      chk("rst_div2_halt", 32'(state), 32'd0);

      // Divisor 0 stored as 1; run and step together favour run
      cfg_div = 8'd0;
      cfg_load = 1'b1;
      tick(1);
      cfg_load = 1'b0;
      tick(1);
      chk("div0_ack", 32'(cfg_ack), 32'd1);
      run = 1'b1;
      step = 1'b1;
      tick(1);
      step = 1'b0;
      chk("div0_run_wins", 32'(state), 32'd1);
      chk("div0_h3_low", 32'(clk_out), 32'd0);
      tick(1);
      chk("div0_h4_high", 32'(clk_out), 32'd1);
      chk("div0_h4_rise", 32'(rise), 32'd1);
      chk("div0_h4_edge_cnt", edge_cnt, 32'd2);
      tick(1);
      chk("div0_h5_low", 32'(clk_out), 32'd0);
      chk("div0_h5_rise", 32'(rise), 32'd0);
      tick(1);
      chk("div0_h6_high", 32'(clk_out), 32'd1);
      chk("div0_h6_edge_cnt", edge_cnt, 32'd3);
      tick(2);
      chk("div0_h8_edge_cnt", edge_cnt, 32'd4);
      run = 1'b0;
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
